// File: rtl/ahb_line_fill.sv
// ahb_line_fill: AHB-Lite read master that fetches one 16-byte I-cache line
// as a 4-beat burst and returns it as a single 128-bit word.
//
// Parameters:
//   WRAP_BURST  0 = INCR4 from the line-aligned address,
//               1 = WRAP4, critical word first.
// Optional feature (macro AHB_FILL_ERR_EN):
//   defined   -> an AHB ERROR response cancels the fill and reports mem_err.
//   undefined -> HRESP is ignored, no mem_err port, all 4 beats complete.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   mem_req/mem_addr  line-fill request and miss address from the I-cache
//   mem_data          assembled line, word k at [32k+31:32k]
//   mem_ready         one-cycle pulse, mem_data valid in the same cycle
//   mem_err           fill ended in a bus error (AHB_FILL_ERR_EN only)
//   HADDR..HWRITE     AHB address/control phase outputs
//   HRDATA/HREADY/HRESP  AHB slave response inputs
module ahb_line_fill #(
  parameter int unsigned WRAP_BURST = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_req,
  input  logic [31:0]  mem_addr,
  output logic [127:0] mem_data,
  output logic         mem_ready,
`ifdef AHB_FILL_ERR_EN
  output logic         mem_err,
`endif
  output logic [31:0]  HADDR,
  output logic [1:0]   HTRANS,
  output logic [2:0]   HBURST,
  output logic [2:0]   HSIZE,
  output logic         HWRITE,
  input  logic [31:0]  HRDATA,
  input  logic         HREADY,
  input  logic         HRESP
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] BURST_TYPE    = (WRAP_BURST != 0) ? 3'b010 : 3'b011;

  state_t         state_q, state_d;
  logic [27:0]    base_q,  base_d;
  logic [1:0]     start_q, start_d;
  logic [2:0]     acnt_q,  acnt_d;   // address phases accepted (0..4)
  logic [2:0]     dcnt_q,  dcnt_d;   // data beats captured (0..4)
  logic [127:0]   data_q,  data_d;
  logic           err_q,   err_d;

  logic [1:0]     a_word;
  logic [1:0]     d_word;
  logic           addr_active;

  logic [1:0]     unused_addr_lsb;
  assign unused_addr_lsb = mem_addr[1:0];

`ifndef AHB_FILL_ERR_EN
  logic unused_hresp;
  assign unused_hresp = HRESP;
`endif

  // 2-bit sums wrap modulo 4, keeping every beat inside the 16-byte line.
  assign a_word      = start_q + acnt_q[1:0];
  assign d_word      = start_q + dcnt_q[1:0];
  assign addr_active = (state_q == BUS) && (acnt_q < 3'd4);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    start_d = start_q;
    acnt_d  = acnt_q;
    dcnt_d  = dcnt_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (mem_req) begin
          state_d = BUS;
          base_d  = mem_addr[31:4];
          start_d = (WRAP_BURST != 0) ? mem_addr[3:2] : 2'b00;
          acnt_d  = '0;
          dcnt_d  = '0;
          err_d   = 1'b0;
        end
      end
      BUS: begin
        if (HREADY) begin
          if (addr_active) acnt_d = acnt_q + 3'd1;
          // A data phase is pending whenever more addresses were accepted
          // than beats captured; address and data phases overlap.
          if (dcnt_q < acnt_q) begin
            data_d[{d_word, 5'd0} +: 32] = HRDATA;
            dcnt_d = dcnt_q + 3'd1;
            if (dcnt_q == 3'd3) state_d = RESP;
          end
        end
`ifdef AHB_FILL_ERR_EN
        else if (HRESP) begin
          // First ERROR cycle: leave BUS so HTRANS goes IDLE next cycle.
          state_d = RESP;
          err_d   = 1'b1;
        end
`endif
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      start_q <= '0;
      acnt_q  <= '0;
      dcnt_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      start_q <= start_d;
      acnt_q  <= acnt_d;
      dcnt_q  <= dcnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign HADDR     = {base_q, a_word, 2'b00};
  assign HTRANS    = !addr_active ? HTRANS_IDLE :
                     (acnt_q == 3'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
  assign HBURST    = addr_active ? BURST_TYPE : 3'b000;
  assign HSIZE     = 3'b010;
  assign HWRITE    = 1'b0;
  assign mem_ready = (state_q == RESP);
  assign mem_data  = data_q;
`ifdef AHB_FILL_ERR_EN
  assign mem_err   = (state_q == RESP) && err_q;
`endif

endmodule

// File: doc/ahb_line_fill.md
AHB_LINE_FILL -- requirements
Module: ahb_line_fill

Interface
REQ-001 SHALL have parameter WRAP_BURST, default 0; 0 = INCR4 from the line-aligned address, 1 = WRAP4 critical-word-first.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 mem_req  input  1  line-fill request from the I-cache, level, held until mem_ready.
REQ-006 mem_addr  input  32  miss address from the I-cache; bits [3:2] = critical word.
REQ-007 mem_data  output  128  assembled line; word k at bits [32k+31:32k].
REQ-008 mem_ready  output  1  one-cycle pulse; mem_data is valid in the same cycle.
REQ-009 mem_err  output  1  bus error on the fill, valid with mem_ready; exists only with AHB_FILL_ERR_EN.
REQ-010 HADDR  output  32  AHB address.
REQ-011 HTRANS  output  2  AHB transfer type.
REQ-012 HBURST  output  3  AHB burst type.
REQ-013 HSIZE  output  3  AHB transfer size; constant 3'b010.
REQ-014 HWRITE  output  1  AHB write flag; constant 0.
REQ-015 HRDATA  input  32  AHB read data.
REQ-016 HREADY  input  1  AHB transfer-complete / wait-state signal.
REQ-017 HRESP  input  1  AHB response; 1 = ERROR.

Function
REQ-018 FSM states SHALL be IDLE, BUS and RESP. Transitions: IDLE->BUS on mem_req=1; BUS->RESP after the 4th data beat is captured; RESP->IDLE unconditionally.
REQ-019 On IDLE accept, the block SHALL latch base = {mem_addr[31:4],4'b0} and start = mem_addr[3:2] (start forced to 0 when WRAP_BURST=0).
REQ-020 Beat i (i=0..3) SHALL address word w_i = (start+i) mod 4, with HADDR = base | (w_i<<2); the address wraps within the 16-byte line.
REQ-021 Transfer types: HTRANS=NONSEQ(10) for beat 0; SEQ(11) for beats 1-3; IDLE(00) once all 4 addresses are accepted, and in IDLE/RESP states.
REQ-022 HBURST SHALL be INCR4(011) when WRAP_BURST=0 and WRAP4(010) when WRAP_BURST=1, and SHALL be SINGLE(000) when not transferring.
REQ-023 An address phase is accepted at an edge where HREADY=1; HADDR/HTRANS SHALL hold stable while HREADY=0.
REQ-024 Data for beat i SHALL be captured from HRDATA into mem_data word w_i at the first HREADY=1 edge after beat i's address was accepted. Address and data phases overlap (pipelined).
REQ-025 Latency with zero wait states: mem_req sampled at edge E0, NONSEQ driven E0-E1, data captured E2..E5, mem_ready high E5-E6. Total 6 cycles; each wait state adds 1 cycle.
REQ-026 mem_req SHALL be ignored in BUS and RESP. The cache deasserts mem_req by the edge ending the mem_ready cycle; a still-high mem_req in IDLE starts a new fill.
REQ-027 mem_data SHALL hold its value from RESP until the next fill overwrites it word by word.

Reset
REQ-028 On rst=1 at an edge, outputs SHALL be: state=IDLE, HTRANS=00, HADDR=0, HBURST=000, mem_ready=0, mem_data=0, mem_err=0. Rest-of-burst beats are abandoned.
REQ-029 Reset during BUS SHALL drive HTRANS=IDLE from the following cycle, with no mem_ready pulse for the aborted fill.

Configuration
REQ-030 Macro AHB_FILL_ERR_EN defined: on HRESP=1 with HREADY=0 (first error cycle), the block SHALL drive HTRANS=IDLE next cycle, cancel remaining beats, go to RESP, and pulse mem_ready with mem_err=1. mem_data is undefined.
REQ-031 Macro AHB_FILL_ERR_EN undefined: HRESP SHALL be ignored, the mem_err port SHALL be absent, and all 4 beats always complete.

Verification
REQ-032 Zero-wait fill, WRAP_BURST=0, mem_addr=0x0000_1238 -> HADDR 0x1230,0x1234,0x1238,0x123C with NONSEQ,SEQ,SEQ,SEQ; mem_ready at cycle 6; mem_data={D3,D2,D1,D0}.
REQ-033 WRAP_BURST=1, mem_addr=0x0000_1238 -> HADDR 0x1238,0x123C,0x1230,0x1234; HBURST=010; each word lands at its own offset.
REQ-034 HREADY low 2 cycles during beat 2 data phase -> HADDR/HTRANS held; mem_ready at cycle 8; data correct.
REQ-035 rst asserted during beat 1 -> HTRANS=00 next cycle, no mem_ready; a new mem_req after reset completes normally.
REQ-036 AHB_FILL_ERR_EN defined, HRESP=1 on beat 1 -> HTRANS=00 next cycle, mem_ready=1 with mem_err=1, 2 beats total.
REQ-037 mem_req held high across mem_ready -> exactly one new fill starts from IDLE on the following cycle; no duplicate or overlapping bursts.
